// File: rtl/mbist_march_ctrl_if.sv
// Address generator and memory-under-test port bundle for the March C- sequencer.
interface mbist_march_ctrl_if #(
  parameter int unsigned ADDR = 8,
  parameter int unsigned DW   = 8
);
  logic [1:0]      addr_en;
  logic            addr_ff;
  logic            addr_done;
  logic [ADDR-1:0] addr;
  logic            mem_cs;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport master (
    output addr_en, addr_ff, mem_cs, mem_we, mem_wdata,
    input  addr_done, addr, mem_rdata
  );

  modport slave (
    input  addr_en, addr_ff, mem_cs, mem_we, mem_wdata,
    output addr_done, addr, mem_rdata
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: steps the address generator, issues memory ops, checks reads, logs failures.
module mbist_march_ctrl #(
  parameter int unsigned ADDR = 8,
  parameter int unsigned DW   = 8,
  parameter int unsigned FCW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bist_start,
  output logic            bist_busy,
  output logic            bist_done,
  output logic            bist_fail,
  output logic [FCW-1:0]  fail_cnt,
  output logic [ADDR-1:0] fail_addr,
  output logic [2:0]      fail_elem,
  mbist_march_ctrl_if.master bus
);

  localparam int unsigned EW = 3;
  localparam logic [EW-1:0] LAST_ELEM = EW'(5);

  typedef enum logic [1:0] {IDLE, RUN, ALIGN, DONE} state_t;

  state_t          state_q, state_n;
  logic [EW-1:0]   elem_q, elem_n;
  logic            op_q, op_n;
  logic            last_c, start_acc_c;

  logic [1:0]      addr_en_q, addr_en_n;
  logic            addr_ff_q, addr_ff_n;
  logic            cs_q, cs_n;
  logic            we_q, we_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic            busy_n, done_n;

  logic            rd_vld_q;
  logic [DW-1:0]   exp_q;
  logic [ADDR-1:0] cap_addr_q;
  logic [EW-1:0]   cap_elem_q;
  logic            mismatch_c;

  // E0 and E5 carry a single op per address; the others carry read then write.
  function automatic logic is_single(input logic [EW-1:0] e);
    return (e == EW'(0)) || (e == LAST_ELEM);
  endfunction

  // Background expected by the read of an element (E2/E4 read ones).
  function automatic logic rd_bg(input logic [EW-1:0] e);
    return (e == EW'(2)) || (e == EW'(4));
  endfunction

  // E3..E5 walk the address space downwards.
  function automatic logic elem_dir(input logic [EW-1:0] e);
    return e >= EW'(3);
  endfunction

  // Next-state sequencing plus next-cycle output decode (outputs are flopped).
  always_comb begin
    state_n     = state_q;
    elem_n      = elem_q;
    op_n        = op_q;
    start_acc_c = 1'b0;
    last_c      = is_single(elem_q) | op_q;
    addr_en_n   = 2'b00;
    addr_ff_n   = 1'b0;
    cs_n        = 1'b0;
    we_n        = 1'b0;
    wdata_n     = '0;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bist_start) begin
          state_n     = RUN;
          elem_n      = '0;
          op_n        = 1'b0;
          start_acc_c = 1'b1;
        end
      end
      RUN: begin
        if (!last_c) begin
          op_n = 1'b1;
        end else begin
          op_n = 1'b0;
          if (bus.addr_done) begin
            if (elem_q == LAST_ELEM) begin
              state_n = ALIGN;
              elem_n  = '0;
            end else begin
              elem_n = elem_q + EW'(1);
            end
          end
        end
      end
      ALIGN:   state_n = DONE;
      default: state_n = IDLE;
    endcase

    case (state_n)
      RUN: begin
        busy_n    = 1'b1;
        cs_n      = 1'b1;
        addr_en_n = {is_single(elem_n) | op_n, elem_dir(elem_n)};
        we_n      = (elem_n == EW'(0)) | op_n;
        if (elem_n != EW'(0) && op_n) wdata_n = {DW{~rd_bg(elem_n)}};
        // E2 write at the top address is its final advance: hold so E3 starts at MAX.
        addr_ff_n = (state_q == RUN) && (elem_n == EW'(2)) && op_n && (bus.addr == '1);
      end
      ALIGN: begin
        busy_n    = 1'b1;
        addr_en_n = 2'b10;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  // State and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      elem_q    <= '0;
      op_q      <= 1'b0;
      addr_en_q <= 2'b00;
      addr_ff_q <= 1'b0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      elem_q    <= elem_n;
      op_q      <= op_n;
      addr_en_q <= addr_en_n;
      addr_ff_q <= addr_ff_n;
      cs_q      <= cs_n;
      we_q      <= we_n;
      wdata_q   <= wdata_n;
      bist_busy <= busy_n;
      bist_done <= done_n;
    end
  end

  assign bus.addr_en   = addr_en_q;
  assign bus.addr_ff   = addr_ff_q;
  assign bus.mem_cs    = cs_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;

  // Read-compare pipe: capture expectation on the read cycle, compare on the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      exp_q      <= '0;
      cap_addr_q <= '0;
      cap_elem_q <= '0;
    end else begin
      rd_vld_q   <= (state_q == RUN) && cs_q && !we_q;
      exp_q      <= {DW{rd_bg(elem_q)}};
      cap_addr_q <= bus.addr;
      cap_elem_q <= elem_q;
    end
  end

  assign mismatch_c = rd_vld_q && (bus.mem_rdata != exp_q);

  // Failure log: sticky flag, saturating count, first-fail location.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bist_fail <= 1'b0;
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (start_acc_c) begin
      bist_fail <= 1'b0;
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (mismatch_c) begin
      bist_fail <= 1'b1;
      if (fail_cnt != '1) fail_cnt <= fail_cnt + FCW'(1);
      if (!bist_fail) begin
        fail_addr <= cap_addr_q;
        fail_elem <= cap_elem_q;
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two lockstep instances (FCW=8 with fault injection, FCW=2 with inverted reads).
module tb_mbist_march_ctrl;
  localparam int unsigned ADDR     = 4;
  localparam int unsigned DW       = 8;
  localparam int unsigned NADDR    = 16;
  localparam int unsigned RUN_LEN  = 160;
  localparam int unsigned DONE_LAT = 162;

  logic clk = 1'b0;
  logic rst_n;
  logic bist_start;
  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.ADDR(ADDR), .DW(DW)) bus_a ();
  mbist_march_ctrl_if #(.ADDR(ADDR), .DW(DW)) bus_b ();

  logic            busy_a, done_a, fail_a, busy_b, done_b, fail_b;
  logic [7:0]      cnt_a;
  logic [1:0]      cnt_b;
  logic [ADDR-1:0] faddr_a, faddr_b;
  logic [2:0]      felem_a, felem_b;

  mbist_march_ctrl #(.ADDR(ADDR), .DW(DW), .FCW(8)) dut (
    .clk(clk), .rst_n(rst_n), .bist_start(bist_start),
    .bist_busy(busy_a), .bist_done(done_a), .bist_fail(fail_a),
    .fail_cnt(cnt_a), .fail_addr(faddr_a), .fail_elem(felem_a), .bus(bus_a));

  mbist_march_ctrl #(.ADDR(ADDR), .DW(DW), .FCW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bist_start(bist_start),
    .bist_busy(busy_b), .bist_done(done_b), .bist_fail(fail_b),
    .fail_cnt(cnt_b), .fail_addr(faddr_b), .fail_elem(felem_b), .bus(bus_b));

  // Address generator + memory models (one per instance).
  int              fault_mode;
  logic [ADDR-1:0] ga, gb, ra, rb;
  logic [DW-1:0]   mem_a [NADDR];
  logic [DW-1:0]   mem_b [NADDR];
  logic [DW-1:0]   raw_a, raw_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ga <= '0;
      gb <= '0;
    end else begin
      if (bus_a.addr_en[1] && !bus_a.addr_ff) ga <= bus_a.addr_en[0] ? ga - ADDR'(1) : ga + ADDR'(1);
      if (bus_b.addr_en[1] && !bus_b.addr_ff) gb <= bus_b.addr_en[0] ? gb - ADDR'(1) : gb + ADDR'(1);
    end
  end

  assign bus_a.addr      = ga;
  assign bus_b.addr      = gb;
  assign bus_a.addr_done = bus_a.addr_en[0] ? (ga == '0) : (ga == '1);
  assign bus_b.addr_done = bus_b.addr_en[0] ? (gb == '0) : (gb == '1);

  always @(posedge clk) begin
    if (bus_a.mem_cs) begin
      if (bus_a.mem_we) mem_a[ga] <= bus_a.mem_wdata;
      else begin raw_a <= mem_a[ga]; ra <= ga; end
    end
    if (bus_b.mem_cs) begin
      if (bus_b.mem_we) mem_b[gb] <= bus_b.mem_wdata;
      else begin raw_b <= mem_b[gb]; rb <= gb; end
    end
  end

  // mode 1: bit0 stuck-at-1 at addr 9; mode 2: bit0 stuck-at-0 at addr 3.
  assign bus_a.mem_rdata = (fault_mode == 1 && ra == ADDR'(9)) ? (raw_a | DW'(1)) :
                           (fault_mode == 2 && ra == ADDR'(3)) ? (raw_a & ~DW'(1)) : raw_a;
  assign bus_b.mem_rdata = ~raw_b;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic            we;
    logic [DW-1:0]   wdata;
    logic [1:0]      addr_en;
    logic            ff;
    logic [ADDR-1:0] addr;
  } op_t;

  op_t sb_q[$];

  // Reference March C- op stream, derived from the element table.
  task automatic build_trace();
    op_t o;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < int'(NADDR); i++) begin
        int a;
        int nops;
        a    = (e >= 3) ? int'(NADDR) - 1 - i : i;
        nops = (e == 0 || e == 5) ? 1 : 2;
        for (int k = 0; k < nops; k++) begin
          o.we      = (e == 0) || (k == 1);
          o.wdata   = (o.we && k == 1 && (e == 1 || e == 3)) ? {DW{1'b1}} : '0;
          o.addr_en = {k == nops - 1, e >= 3};
          o.ff      = (e == 2) && (k == 1) && (a == int'(NADDR) - 1);
          o.addr    = ADDR'(a);
          sb_q.push_back(o);
        end
      end
    end
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({busy_a, done_a, fail_a, cnt_a, faddr_a, felem_a, bus_a.addr_en,
                bus_a.addr_ff, bus_a.mem_cs, bus_a.mem_we, bus_a.mem_wdata});
  endfunction

  function automatic logic [31:0] outs_b();
    return 32'({busy_b, done_b, fail_b, cnt_b, faddr_b, felem_b, bus_b.addr_en,
                bus_b.addr_ff, bus_b.mem_cs, bus_b.mem_we, bus_b.mem_wdata});
  endfunction

  typedef struct {
    int         fault;
    bit         start_mid;
    logic       exp_fail;
    logic [7:0] exp_cnt;
    logic [3:0] exp_addr;
    logic [2:0] exp_elem;
  } vec_t;

  vec_t vecs[4];

  // One full march; abort_at>0 asserts reset at that cycle instead of finishing.
  task automatic run_march(input vec_t v, input int abort_at);
    op_t act, exp;
    int  cyc, run_cyc, done_at;
    fault_mode = v.fault;
    sb_q.delete();
    build_trace();
    @(negedge clk);
    bist_start = 1'b1;
    cyc = 0; run_cyc = 0; done_at = 0;
    while (cyc < 400 && done_at == 0) begin
      @(negedge clk);
      cyc++;
      bist_start = 1'b0;
      if (cyc == 1)
        check("start_clears", 32'({busy_a, done_a, fail_a, cnt_a}), 32'({1'b1, 1'b0, 1'b0, 8'd0}));
      if (bus_a.mem_cs) begin
        run_cyc++;
        act = '{we: bus_a.mem_we, wdata: bus_a.mem_we ? bus_a.mem_wdata : '0,
                addr_en: bus_a.addr_en, ff: bus_a.addr_ff, addr: ga};
        if (sb_q.size() == 0) check("op_trace_overrun", 32'(act), 32'hFFFF_FFFF);
        else begin
          exp = sb_q.pop_front();
          check("op_trace", 32'(act), 32'(exp));
        end
      end
      if (cyc == int'(RUN_LEN) + 1)
        check("align_outs", 32'({busy_a, bus_a.addr_en, bus_a.mem_cs}), 32'({1'b1, 2'b10, 1'b0}));
      if (done_a) done_at = cyc;
      if (v.start_mid && cyc == 50) bist_start = 1'b1;
      if (abort_at > 0 && cyc == abort_at) begin
        check("fail_before_reset", 32'(fail_a), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async_reset_a", outs_a(), 32'(0));
        check("async_reset_b", outs_b(), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        return;
      end
    end
    check("done_latency", 32'(done_at), 32'(DONE_LAT));
    check("run_cycles", 32'(run_cyc), 32'(RUN_LEN));
    check("trace_left", 32'(sb_q.size()), 32'(0));
    check("addr_home", 32'(ga), 32'(0));
    check("busy_in_done", 32'(busy_a), 32'(0));
    check("fail_flag", 32'(fail_a), 32'(v.exp_fail));
    check("fail_cnt", 32'(cnt_a), 32'(v.exp_cnt));
    check("fail_addr", 32'(faddr_a), 32'(v.exp_addr));
    check("fail_elem", 32'(felem_a), 32'(v.exp_elem));
    check("sat_status", 32'({done_b, fail_b, cnt_b, faddr_b, felem_b}),
          32'({1'b1, 1'b1, 2'd3, 4'd0, 3'd1}));
  endtask

  initial begin
    vecs[0] = '{fault: 0, start_mid: 1'b0, exp_fail: 1'b0, exp_cnt: 8'd0, exp_addr: 4'd0, exp_elem: 3'd0};
    vecs[1] = '{fault: 1, start_mid: 1'b0, exp_fail: 1'b1, exp_cnt: 8'd3, exp_addr: 4'd9, exp_elem: 3'd1};
    vecs[2] = '{fault: 2, start_mid: 1'b1, exp_fail: 1'b1, exp_cnt: 8'd2, exp_addr: 4'd3, exp_elem: 3'd2};
    vecs[3] = '{fault: 0, start_mid: 1'b1, exp_fail: 1'b0, exp_cnt: 8'd0, exp_addr: 4'd0, exp_elem: 3'd0};

    fault_mode = 0;
    bist_start = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", outs_a(), 32'(0));
    check("reset_b", outs_b(), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_march(vecs[i], 0);

    // Mid-test reset with a fault already logged, then a clean rerun.
    run_march(vecs[1], 70);
    check("idle_after_reset", 32'({busy_a, done_a, ga}), 32'(0));
    run_march(vecs[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
